// File: rtl/countdown_pkg.sv
// -----------------------------------------------------------------------------
// countdown_pkg
// Shared types and helpers for the countdown timer slice.
//   state_t      : timer control state (IDLE, RUN).
//   presc_width(): bit width needed for a prescaler counting 0..PRESCALE-1,
//                  never less than 1 so PRESCALE=1 still yields a legal vector.
// -----------------------------------------------------------------------------
package countdown_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int PRESC_W_MIN = 1;

    function automatic int presc_width(input int presc);
        int w;
        w = $clog2(presc);
        return (w < PRESC_W_MIN) ? PRESC_W_MIN : w;
    endfunction

endpackage

// File: rtl/countdown_timer_clk_prescaler.sv
// -----------------------------------------------------------------------------
// clk_prescaler
// Divides an advance qualifier into one strobe every PRESCALE advanced cycles.
// Progress is kept while adv is low, so pauses only delay the next strobe.
//   Parameters : PRESCALE (1 .. 2^16) advanced cycles per strobe
//   Ports      : clk     in  clock, rising edge
//                rst     in  synchronous active-high reset
//                clr     in  restart the count from 0 (load)
//                adv     in  count this cycle
//                strobe  out high in the advanced cycle that completes a period
// -----------------------------------------------------------------------------
module clk_prescaler
    import countdown_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic adv,
    output logic strobe
);

    localparam int              PW   = presc_width(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LAST);

    // With PRESCALE=1 LAST is 0 and r_cnt never leaves 0, so strobe == adv.
    assign strobe = adv && w_at_last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (adv) begin
            r_cnt <= w_at_last ? '0 : r_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// Loadable down-counter. Loaded with a start value, it decrements once per
// prescaled enable strobe and pulses done for one cycle at terminal count.
// Optional build macro COUNTDOWN_AUTORELOAD_EN: the terminal event reloads the
// last loaded value and keeps running, giving a periodic done pulse.
//   Parameters : WIDTH    (2..32)    width of load_val / count
//                PRESCALE (1..2^16)  enabled cycles per decrement
//   Ports      : clk       in  clock, rising edge
//                rst       in  synchronous active-high reset
//                load      in  capture load_val and start (0 means stop)
//                load_val  in  start / reload value
//                en        in  run permission; low freezes count and prescaler
//                count     out remaining count (registered)
//                busy      out high while running (registered)
//                done      out one-cycle terminal pulse (registered)
// -----------------------------------------------------------------------------
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic             r_done;
    logic             w_done_next;
    logic             w_adv;
    logic             w_strobe;
`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_next;
`endif

    // The prescaler only moves while running and permitted; a load restarts it.
    assign w_adv = (r_state == RUN) && en;

    clk_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clr    (load),
        .adv    (w_adv),
        .strobe (w_strobe)
    );

    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_done_next   = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
        w_reload_next = r_reload;
`endif
        if (load) begin
            // Load outranks a same-cycle decrement or terminal event, so no done.
            w_count_next  = load_val;
            w_state_next  = (load_val != '0) ? RUN : IDLE;
`ifdef COUNTDOWN_AUTORELOAD_EN
            w_reload_next = load_val;
`endif
        end else if (w_strobe) begin
            // w_strobe implies RUN. Compare with >1 so the count cannot wrap.
            if (r_count > WIDTH'(1)) begin
                w_count_next = r_count - WIDTH'(1);
            end else begin
                w_done_next  = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                w_count_next = r_reload;
`else
                w_count_next = '0;
                w_state_next = IDLE;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_done   <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
            r_reload <= '0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_done   <= w_done_next;
`ifdef COUNTDOWN_AUTORELOAD_EN
            r_reload <= w_reload_next;
`endif
        end
    end

    assign count = r_count;
    assign busy  = (r_state == RUN);
    assign done  = r_done;

endmodule
